// File: rtl/fracnet_mac_pkg.sv
// Shared types and helpers for the FracNet multiply-accumulate pipeline.
// Mode encoding, beat sideband and a width-generic signed saturator.
package fracnet_mac_pkg;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_ACC = 1'b1
    } mode_e;

    typedef struct packed {
        mode_e mode;
        logic  first;
        logic  last;
    } side_t;

    // Saturation works on a 64-bit carrier; callers sign-extend in and truncate out.
    localparam int unsigned SAT_W = 64;

    typedef struct packed {
        logic signed [SAT_W-1:0] value;
        logic                    clip;
    } sat_t;

    function automatic sat_t saturate(input logic signed [SAT_W-1:0] v,
                                      input int unsigned w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sat_t r;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        r.value = v;
        r.clip  = 1'b0;
        if (v > hi) begin
            r.value = hi;
            r.clip  = 1'b1;
        end else if (v < lo) begin
            r.value = lo;
            r.clip  = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fracnet_mul_pipe.sv
// Signed A_W x B_W multiplier with MUL_STAGE product registers and a shared
// clock enable; the sideband and valid travel alongside the product.
module fracnet_mul_pipe
    import fracnet_mac_pkg::*;
#(
    parameter int unsigned A_W       = 16,
    parameter int unsigned B_W       = 10,
    parameter int unsigned MUL_STAGE = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ce,
    input  logic                        valid,
    input  logic signed [A_W-1:0]       a,
    input  logic signed [B_W-1:0]       b,
    input  side_t                       side,
    output logic                        prod_valid,
    output logic signed [A_W+B_W-1:0]   prod,
    output side_t                       prod_side
);

    localparam int unsigned P_W = A_W + B_W;

    logic signed [P_W-1:0] a_ext;
    logic signed [P_W-1:0] b_ext;
    logic signed [P_W-1:0] prod_q  [MUL_STAGE];
    side_t                 side_q  [MUL_STAGE];
    logic [MUL_STAGE-1:0]  valid_q;

    assign a_ext = {{B_W{a[A_W-1]}}, a};
    assign b_ext = {{A_W{b[B_W-1]}}, b};

    // The first register absorbs the multiply; later ones retime into the DSP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < MUL_STAGE; i++) begin
                prod_q[i] <= '0;
                side_q[i] <= '0;
            end
        end else if (ce) begin
            prod_q[0]  <= a_ext * b_ext;
            side_q[0]  <= side;
            valid_q[0] <= valid;
            for (int unsigned i = 1; i < MUL_STAGE; i++) begin
                prod_q[i]  <= prod_q[i-1];
                side_q[i]  <= side_q[i-1];
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    assign prod       = prod_q[MUL_STAGE-1];
    assign prod_side  = side_q[MUL_STAGE-1];
    assign prod_valid = valid_q[MUL_STAGE-1];

endmodule

// File: rtl/fracnet_mac_pipe.sv
// Pipelined signed MAC: per-beat product or accumulate mode, saturating
// result with clip flag, valid/ready backpressure via one global enable.
module fracnet_mac_pipe
    import fracnet_mac_pkg::*;
#(
    parameter int unsigned A_W       = 16,
    parameter int unsigned B_W       = 10,
    parameter int unsigned ACC_W     = 32,
    parameter int unsigned OUT_W     = 27,
    parameter int unsigned MUL_STAGE = 2
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [A_W-1:0]   in_a,
    input  logic signed [B_W-1:0]   in_b,
    input  logic                    in_mode,
    input  logic                    in_first,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_sat
);

    localparam int unsigned P_W = A_W + B_W;

    logic                    ce;
    side_t                   in_side;
    logic                    prod_valid;
    logic signed [P_W-1:0]   prod;
    side_t                   prod_side;

    logic signed [ACC_W-1:0] acc;
    logic                    sticky;
    logic                    open;

    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [SAT_W-1:0] sum_wide;
    logic signed [SAT_W-1:0] out_src;
    logic                    start;
    logic                    sticky_next;
    sat_t                    acc_sat;
    sat_t                    res_sat;
    logic                    unused_hi;

    assign ce       = !out_valid || out_ready;
    assign in_ready = ce;
    assign in_side  = '{mode: mode_e'(in_mode), first: in_first, last: in_last};

    fracnet_mul_pipe #(
        .A_W       (A_W),
        .B_W       (B_W),
        .MUL_STAGE (MUL_STAGE)
    ) u_mul (
        .clk        (ap_clk),
        .rst_n      (ap_rst_n),
        .ce         (ce),
        .valid      (in_valid),
        .a          (in_a),
        .b          (in_b),
        .side       (in_side),
        .prod_valid (prod_valid),
        .prod       (prod),
        .prod_side  (prod_side)
    );

    // A fresh product always fits ACC_W, so only the running sum can clip.
    always_comb begin
        prod_ext    = ACC_W'(prod);
        start       = prod_side.first || !open;
        sum_wide    = start ? SAT_W'(prod_ext) : SAT_W'(acc) + SAT_W'(prod_ext);
        acc_sat     = saturate(sum_wide, ACC_W);
        acc_next    = acc_sat.value[ACC_W-1:0];
        sticky_next = start ? 1'b0 : (sticky || acc_sat.clip);
        out_src     = (prod_side.mode == MODE_MUL) ? SAT_W'(prod_ext) : SAT_W'(acc_next);
        res_sat     = saturate(out_src, OUT_W);
    end

    assign unused_hi = ^{acc_sat.value[SAT_W-1:ACC_W], res_sat.value[SAT_W-1:OUT_W]};

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc       <= '0;
            sticky    <= 1'b0;
            open      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (ce) begin
            out_valid <= 1'b0;
            if (prod_valid) begin
                if (prod_side.mode == MODE_MUL) begin
                    out_valid <= 1'b1;
                    out_data  <= res_sat.value[OUT_W-1:0];
                    out_sat   <= res_sat.clip;
                end else if (prod_side.last) begin
                    out_valid <= 1'b1;
                    out_data  <= res_sat.value[OUT_W-1:0];
                    out_sat   <= sticky_next || res_sat.clip;
                    acc       <= '0;
                    sticky    <= 1'b0;
                    open      <= 1'b0;
                end else begin
                    acc    <= acc_next;
                    sticky <= sticky_next;
                    open   <= 1'b1;
                end
            end
        end
    end

endmodule
